// File: rtl/mc_control_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_if
// Description : Control/status bundle between the multicycle controller and
//               its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_if #(
    parameter int INSTR_WIDTH   = 32,
    parameter int ALUCTRL_WIDTH = 4,
    parameter int IMMSRC_WIDTH  = 3
);
    logic [INSTR_WIDTH-1:0]   Instruction;
    logic                     ZERO;
    logic                     mem_ready;
    logic                     PCWrite;
    logic                     AdrSrc;
    logic                     IRWrite;
    logic                     MemWrite;
    logic                     RegWrite;
    logic [1:0]               ResultSrc;
    logic [1:0]               ALUSrcA;
    logic [1:0]               ALUSrcB;
    logic [ALUCTRL_WIDTH-1:0] ALUctrl;
    logic [IMMSRC_WIDTH-1:0]  Immsrc;
    logic [3:0]               State_Out;
    logic                     instr_done;
    logic                     trap;
    logic [31:0]              instret;

    modport master (
        input  Instruction, ZERO, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUctrl, Immsrc, State_Out, instr_done,
               trap, instret
    );

    modport slave (
        output Instruction, ZERO, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUctrl, Immsrc, State_Out, instr_done,
               trap, instret
    );
endinterface
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_control
// Description : Multicycle RISC-V style Moore controller with memory wait
//               states, illegal-opcode trap and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control #(
    parameter int INSTR_WIDTH   = 32,
    parameter int ALUCTRL_WIDTH = 4,
    parameter int IMMSRC_WIDTH  = 3
) (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_EXECI   = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_LUI     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_add = ALUCTRL_WIDTH'(0);
    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_sub = ALUCTRL_WIDTH'(1);
    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_and = ALUCTRL_WIDTH'(2);
    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_or  = ALUCTRL_WIDTH'(3);
    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_xor = ALUCTRL_WIDTH'(4);
    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_sll = ALUCTRL_WIDTH'(5);
    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_srl = ALUCTRL_WIDTH'(6);
    localparam logic [ALUCTRL_WIDTH-1:0] c_alu_slt = ALUCTRL_WIDTH'(7);

    localparam logic [IMMSRC_WIDTH-1:0] c_imm_i = IMMSRC_WIDTH'(0);
    localparam logic [IMMSRC_WIDTH-1:0] c_imm_s = IMMSRC_WIDTH'(1);
    localparam logic [IMMSRC_WIDTH-1:0] c_imm_b = IMMSRC_WIDTH'(2);
    localparam logic [IMMSRC_WIDTH-1:0] c_imm_j = IMMSRC_WIDTH'(3);
    localparam logic [IMMSRC_WIDTH-1:0] c_imm_u = IMMSRC_WIDTH'(4);

    // Only the operation subset the ALU provides: SLTU folds onto SLT, SRA onto SRL.
    function automatic logic [ALUCTRL_WIDTH-1:0] alu_op(input logic [2:0] f3,
                                                        input logic f7_5,
                                                        input logic is_reg);
        case (f3)
            3'b000:  alu_op = (is_reg && f7_5) ? c_alu_sub : c_alu_add;
            3'b001:  alu_op = c_alu_sll;
            3'b010:  alu_op = c_alu_slt;
            3'b011:  alu_op = c_alu_slt;
            3'b100:  alu_op = c_alu_xor;
            3'b101:  alu_op = c_alu_srl;
            3'b110:  alu_op = c_alu_or;
            default: alu_op = c_alu_and;
        endcase
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_adr_src,   w_adr_src;
    logic                     r_mem_write, w_mem_write;
    logic                     r_reg_write, w_reg_write;
    logic                     r_pc_jump,   w_pc_jump;
    logic                     r_trap,      w_trap;
    logic [1:0]               r_result_src, w_result_src;
    logic [1:0]               r_alu_src_a,  w_alu_src_a;
    logic [1:0]               r_alu_src_b,  w_alu_src_b;
    logic [ALUCTRL_WIDTH-1:0] r_alu_ctrl,   w_alu_ctrl;
    logic [IMMSRC_WIDTH-1:0]  r_imm_src,    w_imm_src;
    logic                     r_instr_done;
    logic [31:0]              r_instret;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_retire;
    logic       w_branch_taken;
    logic       w_unused;

    assign w_opcode   = bus.Instruction[6:0];
    assign w_funct3   = bus.Instruction[14:12];
    assign w_funct7_5 = bus.Instruction[30];
    assign w_unused   = &{1'b0, bus.Instruction[INSTR_WIDTH-1:31],
                          bus.Instruction[29:15], bus.Instruction[11:7]};

    always_comb begin
        w_state_nxt = r_state;
        if (rst) begin
            w_state_nxt = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (bus.mem_ready) w_state_nxt = S_DECODE;
                S_DECODE: begin
                    case (w_opcode)
                        c_op_load, c_op_store: w_state_nxt = S_MEMADR;
                        c_op_reg:              w_state_nxt = S_EXECR;
                        c_op_imm:              w_state_nxt = S_EXECI;
                        c_op_branch:           w_state_nxt = S_BRANCH;
                        c_op_jal:              w_state_nxt = S_JAL;
                        c_op_lui:              w_state_nxt = S_LUI;
                        default:               w_state_nxt = S_TRAP;
                    endcase
                end
                S_MEMADR:   w_state_nxt = (w_opcode == c_op_store) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (bus.mem_ready) w_state_nxt = S_MEMWB;
                S_MEMWRITE: if (bus.mem_ready) w_state_nxt = S_FETCH;
                S_EXECR, S_EXECI, S_JAL, S_LUI:  w_state_nxt = S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH:      w_state_nxt = S_FETCH;
                default:    w_state_nxt = S_TRAP;
            endcase
        end
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_pc_jump    = 1'b0;
        w_trap       = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_ctrl   = c_alu_add;
        w_imm_src    = c_imm_i;
        case (w_state_nxt)
            S_FETCH:    begin w_alu_src_b = 2'b10; w_result_src = 2'b10; end
            S_DECODE:   begin w_alu_src_a = 2'b01; w_alu_src_b = 2'b01; w_imm_src = c_imm_b; end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = (w_opcode == c_op_store) ? c_imm_s : c_imm_i;
            end
            S_MEMREAD:  w_adr_src = 1'b1;
            S_MEMWRITE: begin w_adr_src = 1'b1; w_mem_write = 1'b1; end
            S_MEMWB:    begin w_result_src = 2'b01; w_reg_write = 1'b1; end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_ctrl  = alu_op(w_funct3, w_funct7_5, 1'b1);
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_ctrl  = alu_op(w_funct3, w_funct7_5, 1'b0);
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BRANCH:   begin w_alu_src_a = 2'b10; w_alu_ctrl = c_alu_sub; end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_jump   = 1'b1;
                w_imm_src   = c_imm_j;
            end
            S_LUI:      begin w_alu_src_a = 2'b10; w_alu_src_b = 2'b01; w_imm_src = c_imm_u; end
            S_TRAP:     w_trap = 1'b1;
            default:    ;
        endcase
    end

    assign w_retire = !rst && (w_state_nxt == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk) begin
        r_state      <= w_state_nxt;
        r_adr_src    <= w_adr_src;
        r_mem_write  <= w_mem_write;
        r_reg_write  <= w_reg_write;
        r_pc_jump    <= w_pc_jump;
        r_trap       <= w_trap;
        r_result_src <= w_result_src;
        r_alu_src_a  <= w_alu_src_a;
        r_alu_src_b  <= w_alu_src_b;
        r_alu_ctrl   <= w_alu_ctrl;
        r_imm_src    <= w_imm_src;
        if (rst) begin
            r_instr_done <= 1'b0;
            r_instret    <= 32'd0;
        end else begin
            r_instr_done <= w_retire;
            if (w_retire) r_instret <= r_instret + 32'd1;
        end
    end

    // beq/bne resolve from the live ZERO flag; other funct3 never redirect.
    assign w_branch_taken = ((w_funct3 == 3'b000) &&  bus.ZERO) ||
                            ((w_funct3 == 3'b001) && !bus.ZERO);

    assign bus.IRWrite    = (r_state == S_FETCH) && bus.mem_ready;
    assign bus.PCWrite    = r_pc_jump || ((r_state == S_FETCH) && bus.mem_ready) ||
                            ((r_state == S_BRANCH) && w_branch_taken);
    assign bus.AdrSrc     = r_adr_src;
    assign bus.MemWrite   = r_mem_write;
    assign bus.RegWrite   = r_reg_write;
    assign bus.ResultSrc  = r_result_src;
    assign bus.ALUSrcA    = r_alu_src_a;
    assign bus.ALUSrcB    = r_alu_src_b;
    assign bus.ALUctrl    = r_alu_ctrl;
    assign bus.Immsrc     = r_imm_src;
    assign bus.State_Out  = r_state;
    assign bus.instr_done = r_instr_done;
    assign bus.trap       = r_trap;
    assign bus.instret    = r_instret;
endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control
// Description : Self-checking bench for mc_control against an instruction-
//               level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] instr_r = 32'h0000_0013;

    int n_vec = 0;
    int n_err = 0;

    mc_control_if #(.INSTR_WIDTH(32), .ALUCTRL_WIDTH(4), .IMMSRC_WIDTH(3)) bus ();
    assign bus.Instruction = instr_r;
    assign bus.ZERO        = zero;
    assign bus.mem_ready   = mem_ready;

    mc_control #(.INSTR_WIDTH(32), .ALUCTRL_WIDTH(4), .IMMSRC_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_state = 0;
    int          m_plan[$];
    logic        m_done = 1'b0;
    logic [31:0] m_instret = 32'd0;
    bit          m_live = 1'b0;

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7b, input bit is_reg);
        case (f3)
            3'd0: return (is_reg && f7b) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2, 3'd3: return 4'd7;
            3'd4: return 4'd4;
            3'd5: return 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [55:0] model_out(input int st, input logic [31:0] ins,
                                              input logic mr, input logic z,
                                              input logic done, input logic [31:0] cnt);
        logic pcw, adr, irw, memw, regw, trp;
        logic [1:0] res, sa, sb;
        logic [3:0] alu;
        logic [2:0] imm, f3;
        logic [3:0] stv;
        {pcw, adr, irw, memw, regw, trp} = '0;
        res = 2'd0; sa = 2'd0; sb = 2'd0; alu = 4'd0; imm = 3'd0;
        f3  = ins[14:12];
        stv = 4'(st);
        case (st)
            0:  begin sb = 2'd2; res = 2'd2; pcw = mr; irw = mr; end
            1:  begin sa = 2'd1; sb = 2'd1; imm = 3'd2; end
            2:  begin sa = 2'd2; sb = 2'd1; imm = (ins[6:0] == 7'b0100011) ? 3'd1 : 3'd0; end
            3:  adr = 1'b1;
            4:  begin res = 2'd1; regw = 1'b1; end
            5:  begin adr = 1'b1; memw = 1'b1; end
            6:  begin sa = 2'd2; alu = alu_ref(f3, ins[30], 1'b1); end
            7:  begin sa = 2'd2; sb = 2'd1; alu = alu_ref(f3, ins[30], 1'b0); end
            8:  regw = 1'b1;
            9:  begin sa = 2'd2; alu = 4'd1; pcw = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? !z : 1'b0); end
            10: begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; imm = 3'd3; end
            11: begin sa = 2'd2; sb = 2'd1; imm = 3'd4; end
            15: trp = 1'b1;
            default: ;
        endcase
        return {stv, pcw, adr, irw, memw, regw, res, sa, sb, alu, imm, trp, done, cnt};
    endfunction

    always @(posedge clk) begin
        logic [55:0] exp_v;
        logic [55:0] act_v;
        m_done = 1'b0;
        if (rst) begin
            m_state = 0; m_instret = 32'd0; m_plan.delete(); m_live = 1'b1;
        end else if (m_state == 15) begin
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 1) begin
                m_plan.delete();
                case (instr_r[6:0])
                    7'b0000011: begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
                    7'b0100011: begin m_plan.push_back(2); m_plan.push_back(5); end
                    7'b0110011: begin m_plan.push_back(6); m_plan.push_back(8); end
                    7'b0010011: begin m_plan.push_back(7); m_plan.push_back(8); end
                    7'b1100011: m_plan.push_back(9);
                    7'b1101111: begin m_plan.push_back(10); m_plan.push_back(8); end
                    7'b0110111: begin m_plan.push_back(11); m_plan.push_back(8); end
                    default:    m_plan.push_back(15);
                endcase
            end
            if (m_plan.size() == 0) begin
                m_state = 0; m_done = 1'b1; m_instret = m_instret + 32'd1;
            end else begin
                m_state = m_plan.pop_front();
            end
        end
        #2;
        if (m_live) begin
            exp_v = model_out(m_state, instr_r, mem_ready, zero, m_done, m_instret);
            act_v = {bus.State_Out, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite,
                     bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUctrl,
                     bus.Immsrc, bus.trap, bus.instr_done, bus.instret};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [3:0]  s_state;
    logic        s_pcw, s_irw, s_memw, s_regw, s_done, s_trap;
    logic [3:0]  s_alu;
    logic [31:0] seq, pcw_bits, regw_bits;
    logic [3:0]  alu_at2;
    int          done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        #1;
        s_state = bus.State_Out; s_pcw = bus.PCWrite; s_irw = bus.IRWrite;
        s_memw  = bus.MemWrite;  s_regw = bus.RegWrite; s_done = bus.instr_done;
        s_trap  = bus.trap;      s_alu = bus.ALUctrl;
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int stall, input bit rnd, input logic z);
        int   left;
        int   guard;
        logic mr;
        logic zz;
        left = stall; guard = 0;
        instr_r = ins;
        seq = 0; pcw_bits = 0; regw_bits = 0; done_cnt = 0; alu_at2 = 0;
        forever begin
            mr = 1'b1; zz = z;
            if ((bus.State_Out == 4'd3 || bus.State_Out == 4'd5) && left > 0) begin
                mr = 1'b0; left--;
            end
            if (rnd) begin
                mr  = ($urandom_range(0, 3) != 0);
                zz  = 1'($urandom_range(0, 1));
                rst = ($urandom_range(0, 59) == 0);
            end
            step(mr, zz);
            seq       = (seq << 4) | 32'(s_state);
            pcw_bits  = (pcw_bits << 1) | 32'(s_pcw);
            regw_bits = (regw_bits << 1) | 32'(s_regw);
            if (guard == 2) alu_at2 = s_alu;
            if (guard > 0 && s_done) done_cnt++;
            guard++;
            if (bus.State_Out == 4'd0 || bus.State_Out == 4'd15 || guard >= 60) break;
        end
        rst = 1'b0;
        if (guard >= 60) check("run_timeout", 32'(guard), 32'd0);
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        logic [6:0]  ops [7];
        logic [31:0] ins;
        int          ok;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111};

        @(negedge clk);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        check("reset_state", 32'(s_state), 32'd0);
        check("reset_enables", {28'd0, s_pcw, s_irw, s_memw, s_regw}, 32'd0);
        check("reset_instret", bus.instret, 32'd0);
        check("reset_trap", 32'(s_trap), 32'd0);

        // sub x3,x1,x2
        run_instr(32'h4020_81B3, 0, 1'b0, 1'b0);
        check("sub_states", seq, 32'h0000_0168);
        check("sub_aluctrl", 32'(alu_at2), 32'd1);
        check("sub_regwrite", regw_bits, 32'b0001);
        check("sub_done", 32'(bus.instr_done), 32'd1);
        check("sub_instret", bus.instret, 32'd1);

        // lw x5,8(x1) with three MEMREAD stalls
        run_instr(32'h0080_A283, 3, 1'b0, 1'b0);
        check("lw_states", seq, 32'h0123_3334);
        check("lw_done_pulses", 32'(done_cnt) + 32'(bus.instr_done), 32'd1);
        check("lw_instret", bus.instret, 32'd2);

        run_instr(32'h0020_8463, 0, 1'b0, 1'b1);
        check("beq_states", seq, 32'h0000_0019);
        check("beq_pcwrite", pcw_bits, 32'b101);
        run_instr(32'h0020_9463, 0, 1'b0, 1'b1);
        check("bne_pcwrite", pcw_bits, 32'b100);

        run_instr(32'h0080_00EF, 0, 1'b0, 1'b0);
        check("jal_states", seq, 32'h0000_01A8);
        run_instr(32'h1234_52B7, 0, 1'b0, 1'b0);
        check("lui_states", seq, 32'h0000_01B8);
        run_instr(32'h0010_8093, 0, 1'b0, 1'b0);
        check("addi_states", seq, 32'h0000_0178);
        check("addi_instret", bus.instret, 32'd7);

        // counter wrap
        force dut.r_instret = 32'hFFFF_FFFF;
        m_instret = 32'hFFFF_FFFF;
        step(1'b0, 1'b0);
        release dut.r_instret;
        run_instr(32'h0010_8093, 0, 1'b0, 1'b0);
        check("wrap_instret", bus.instret, 32'd0);

        // illegal opcode
        run_instr(32'h0000_007F, 0, 1'b0, 1'b0);
        check("trap_entry", seq, 32'h0000_0001);
        check("trap_state", 32'(bus.State_Out), 32'd15);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (s_state == 4'd15 && s_trap && !s_pcw && !s_irw && !s_memw && !s_regw) ok++;
        end
        check("trap_hold", 32'(ok), 32'd10);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        check("trap_reset_state", 32'(bus.State_Out), 32'd0);
        check("trap_reset_flag", 32'(bus.trap), 32'd0);

        // reset during a stalled store
        run_instr(32'h0010_8093, 0, 1'b0, 1'b0);
        run_instr(32'h0010_8093, 0, 1'b0, 1'b0);
        instr_r = 32'h0020_A423;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("sw_memwrite", {28'd0, bus.State_Out}, 32'd5);
        step(1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        check("rst_mid_store_state", 32'(bus.State_Out), 32'd0);
        check("rst_mid_store_memwrite", 32'(bus.MemWrite), 32'd0);
        check("rst_mid_store_instret", bus.instret, 32'd0);

        for (int n = 0; n < 300; n++) begin
            ins      = $urandom;
            ins[6:0] = ops[$urandom_range(0, 6)];
            run_instr(ins, 0, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
